nbit_addsub_seq: RTL and testbench
==================================

// Module: nbit_addsub_seq
// PURPOSE
//  Parametrised N-bit two's-complement adder/subtractor, computed CHUNK bits per cycle.
//  Same function as the 4-bit ripple add/sub (M=0 add, M=1 subtract via B^M with carry-in M),
//  extended with C/V/Z flags and valid/ready handshakes on both sides.
//  Sits between an operand source and a result consumer in the datapath.
//  Trades latency for a short carry chain.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be >= 2.
//  CHUNK   4  bits resolved per cycle; WIDTH % CHUNK == 0; CHUNK == WIDTH gives 1 cycle.
// PORTS
//  clk        in   1      single clock; all state updates on the rising edge.
//  rst_n      in   1      asynchronous, active-low reset.
//  in_valid   in   1      operand request.
//  in_ready   out  1      block can accept operands (high only in IDLE).
//  a          in   WIDTH  operand A.
//  b          in   WIDTH  operand B.
//  m          in   1      0 = A+B, 1 = A-B.
//  out_valid  out  1      result/flags valid.
//  out_ready  in   1      consumer accepts result.
//  s          out  WIDTH  sum/difference.
//  c          out  1      carry out of the MSB. For subtract, c=1 means no borrow (A >= B unsigned).
//  v          out  1      signed overflow = carry-into-MSB ^ carry-out-of-MSB.
//  z          out  1      s == 0.
// BEHAVIOUR
//  Reset (async, rst_n low): state=IDLE; s=0, c=0, v=0, z=0, out_valid=0; all internal regs cleared.
//   - in_ready=1 (decoded from state == IDLE).
//   - Reset mid-CALC or mid-DONE aborts the operation; no result is emitted.
//  FSM: IDLE -> CALC -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid & in_ready:
//   - latch a into opA and b^{WIDTH{m}} into opB.
//   - carry=m, idx=0, go to CALC.
//  CALC: each cycle, resolve chunk idx (bits idx*CHUNK +: CHUNK) with the running carry.
//   - store sum bits; update carry; idx++.
//   - On the chunk containing the MSB, also capture carry-into-MSB for v.
//   - After the last chunk (idx == WIDTH/CHUNK-1): register s, c, v, z; set out_valid=1; go to DONE.
//   - Inputs a, b, m, in_valid are ignored (operands already latched).
//  Latency: accept on edge E0; out_valid rises after edge E(WIDTH/CHUNK), i.e. 4 cycles at the defaults.
//  DONE: out_valid=1; s/c/v/z held stable.
//   - On out_ready: out_valid=0 next cycle and return to IDLE.
//   - No accept occurs in the same cycle as the result handoff; next accept is possible one cycle later.
//   - out_ready while not in DONE has no effect.
//  Arithmetic is modulo 2^WIDTH; c and v are computed per the definitions under PORTS.
// CONFIGURATION
//  Macro ADDSUB_SAT_EN.
//  Defined: when v=1, s saturates to {opA[MSB], {WIDTH-1{~opA[MSB]}}}.
//   - Result: 0x7FF..F if A >= 0, 0x800..0 if A < 0.
//   - v still reads 1; c is unchanged (raw carry).
//   - z is evaluated on the saturated s, so z=0 whenever saturation occurs.
//  Undefined: s is the raw wrapped result; no saturation logic is present.
// TESTING (WIDTH=16, CHUNK=4 unless noted)
//  1. a=0x1234, b=0x0FF0, m=0 -> s=0x2224, c=0, v=0, z=0; out_valid exactly 4 cycles after accept.
//  2. a=0x0005, b=0x0005, m=1 -> s=0x0000, c=1, v=0, z=1.
//  3. a=0x7FFF, b=0x0001, m=0 -> raw s=0x8000, c=0, v=1.
//     With ADDSUB_SAT_EN: s=0x7FFF, v=1, z=0.
//  4. a=0x8000, b=0x0001, m=1 -> raw s=0x7FFF, c=1, v=1.
//     With ADDSUB_SAT_EN: s=0x8000.
//  5. Hold out_ready=0 for 3 cycles in DONE -> s/flags/out_valid stable, in_ready=0.
//     A new in_valid during this window is not accepted.
//     Release out_ready -> IDLE, then the next operand is accepted.
//  6. Assert rst_n=0 during CALC (second chunk) -> outputs zero, in_ready=1, no out_valid.
//     Then 0xFFFF+0x0001 -> s=0x0000, c=1, v=0, z=1.
//     Repeat tests 1-3 with CHUNK=16 -> 1-cycle latency, identical results.

Source files
------------

// File: rtl/nbit_addsub_seq.sv
// Sequential N-bit two's-complement adder/subtractor, CHUNK bits resolved per cycle, with C/V/Z flags.
// Optional macro ADDSUB_SAT_EN: saturate s on signed overflow.
module nbit_addsub_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v,
  output logic             z
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             z_q, z_d;
  logic             out_valid_q, out_valid_d;

  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_sum;
  logic             rc, top_cin;

  // Ripple through the current chunk; top_cin is the carry into the chunk's top bit.
  always_comb begin
    chunk_a   = opa_q[int'(idx_q)*CHUNK +: CHUNK];
    chunk_b   = opb_q[int'(idx_q)*CHUNK +: CHUNK];
    chunk_sum = '0;
    rc        = carry_q;
    top_cin   = carry_q;
    for (int i = 0; i < int'(CHUNK); i++) begin
      chunk_sum[i] = chunk_a[i] ^ chunk_b[i] ^ rc;
      if (i == int'(CHUNK) - 1) top_cin = rc;
      rc = (chunk_a[i] & chunk_b[i]) | (chunk_a[i] & rc) | (chunk_b[i] & rc);
    end
  end

  always_comb begin
    state_d     = state_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    s_d         = s_q;
    c_d         = c_q;
    v_d         = v_q;
    z_d         = z_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d   = a;
          opb_d   = b ^ {WIDTH{m}};
          carry_d = m;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d[int'(idx_q)*CHUNK +: CHUNK] = chunk_sum;
        carry_d = rc;
        idx_d   = IDX_W'(idx_q + 1'b1);
        if (idx_q == IDX_W'(NCHUNK - 1)) begin
          c_d = rc;
          v_d = top_cin ^ rc;
`ifdef ADDSUB_SAT_EN
          if (top_cin ^ rc) s_d = {opa_q[WIDTH-1], {(WIDTH-1){~opa_q[WIDTH-1]}}};
          else              s_d = sum_d;
`else
          s_d = sum_d;
`endif
          z_d         = (s_d == '0);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      s_q         <= '0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      s_q         <= s_d;
      c_q         <= c_d;
      v_q         <= v_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign c         = c_q;
  assign v         = v_q;
  assign z         = z_q;

endmodule

// File: tb/tb_nbit_addsub_seq.sv
// Scoreboard bench for nbit_addsub_seq: unit 0 uses CHUNK=4, unit 1 uses CHUNK=16 (single-cycle).
module tb_nbit_addsub_seq;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid_i [2];
  logic        in_ready_o [2];
  logic [15:0] a_i        [2];
  logic [15:0] b_i        [2];
  logic        m_i        [2];
  logic        out_valid_o[2];
  logic        out_ready_i[2];
  logic [15:0] s_o        [2];
  logic        c_o        [2];
  logic        v_o        [2];
  logic        z_o        [2];

  int   n_checks = 0;
  int   n_pass   = 0;
  res_t exp_q[$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    nbit_addsub_seq #(.WIDTH(16), .CHUNK((g == 0) ? 4 : 16)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid_i[g]),
      .in_ready (in_ready_o[g]),
      .a        (a_i[g]),
      .b        (b_i[g]),
      .m        (m_i[g]),
      .out_valid(out_valid_o[g]),
      .out_ready(out_ready_i[g]),
      .s        (s_o[g]),
      .c        (c_o[g]),
      .v        (v_o[g]),
      .z        (z_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: full-width add of A and (B ^ M) + M.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic m);
    res_t        r;
    logic [15:0] bb;
    logic [16:0] sum;
    bb  = b ^ {16{m}};
    sum = {1'b0, a} + {1'b0, bb} + 17'(m);
    r.s = sum[15:0];
    r.c = sum[16];
    r.v = (a[15] == bb[15]) && (sum[15] != a[15]);
`ifdef ADDSUB_SAT_EN
    if (r.v) r.s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    r.z = (r.s == 16'h0000);
    return r;
  endfunction

  task automatic do_op(input int u, input logic [15:0] a, input logic [15:0] b,
                       input logic m, input int hold);
    res_t e;
    int   cyc;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready_o[u]), 32'd1);
    a_i[u] = a; b_i[u] = b; m_i[u] = m; in_valid_i[u] = 1'b1;
    exp_q.push_back(model(a, b, m));
    @(posedge clk); #1;
    in_valid_i[u] = 1'b0;
    cyc = 0;
    while (!out_valid_o[u] && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), (u == 0) ? 32'd4 : 32'd1);
    check("in_ready_busy", 32'(in_ready_o[u]), 32'd0);
    if (exp_q.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      for (int k = 0; k < hold; k++) begin
        in_valid_i[u] = 1'b1; a_i[u] = 16'hAAAA; b_i[u] = 16'h5555;
        @(posedge clk); #1;
        check("hold_valid", 32'(out_valid_o[u]), 32'd1);
        check("hold_in_ready", 32'(in_ready_o[u]), 32'd0);
        check("hold_s", 32'(s_o[u]), 32'(e.s));
        check("hold_cvz", 32'({c_o[u], v_o[u], z_o[u]}), 32'({e.c, e.v, e.z}));
      end
      check("s", 32'(s_o[u]), 32'(e.s));
      check("c", 32'(c_o[u]), 32'(e.c));
      check("v", 32'(v_o[u]), 32'(e.v));
      check("z", 32'(z_o[u]), 32'(e.z));
    end
    out_ready_i[u] = 1'b1;
    @(posedge clk); #1;
    out_ready_i[u] = 1'b0;
    in_valid_i[u]  = 1'b0;
    check("out_valid_drop", 32'(out_valid_o[u]), 32'd0);
    check("in_ready_back", 32'(in_ready_o[u]), 32'd1);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      in_valid_i[u] = 1'b0; out_ready_i[u] = 1'b0;
      a_i[u] = '0; b_i[u] = '0; m_i[u] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_s", 32'(s_o[u]), 32'd0);
      check("rst_cvz", 32'({c_o[u], v_o[u], z_o[u]}), 32'd0);
      check("rst_out_valid", 32'(out_valid_o[u]), 32'd0);
      check("rst_in_ready", 32'(in_ready_o[u]), 32'd1);
    end
    rst_n = 1'b1;

    do_op(0, 16'h1234, 16'h0FF0, 1'b0, 0);
    do_op(0, 16'h0005, 16'h0005, 1'b1, 0);
    do_op(0, 16'h7FFF, 16'h0001, 1'b0, 0);
    do_op(0, 16'h8000, 16'h0001, 1'b1, 3);

    // Abort during the second chunk.
    @(negedge clk);
    a_i[0] = 16'h4321; b_i[0] = 16'h1111; m_i[0] = 1'b0; in_valid_i[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_i[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_s", 32'(s_o[0]), 32'd0);
    check("abort_cvz", 32'({c_o[0], v_o[0], z_o[0]}), 32'd0);
    check("abort_out_valid", 32'(out_valid_o[0]), 32'd0);
    check("abort_in_ready", 32'(in_ready_o[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid_o[0]) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    do_op(0, 16'hFFFF, 16'h0001, 1'b0, 0);

    for (int k = 0; k < 6; k++)
      do_op(0, 16'($urandom), 16'($urandom), 1'($urandom), k % 2);

    do_op(1, 16'h1234, 16'h0FF0, 1'b0, 0);
    do_op(1, 16'h0005, 16'h0005, 1'b1, 0);
    do_op(1, 16'h7FFF, 16'h0001, 1'b0, 1);
    for (int k = 0; k < 3; k++)
      do_op(1, 16'($urandom), 16'($urandom), 1'($urandom), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
